check_scoreboard: RTL

//  Downstream consumer of the instruction checker's OpDone. Tracks every issued instruction
//  (pcEn pulse) through a CHK_LAT-deep delay line, matches it against OpDone and tallies

---
 rtl/check_scoreboard.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/check_scoreboard.sv
// Scoreboard that follows each issued instruction through a fixed-latency delay line,
// scores the matching OpDone and reports a per-run verdict with the first failing word.
`timescale 1ns/1ps
module check_scoreboard #(
  parameter int CHK_LAT = 5,
  parameter int CNT_W   = 16,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_insts,
  input  logic [TO_W-1:0]  timeout_lim,
  input  logic [31:0]      inst,
  input  logic             pcEn,
  input  logic             OpDone,
  output logic             busy,
  output logic             done,
  output logic             test_pass,
  output logic             timeout,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] spur_cnt,
  output logic             first_fail_vld,
  output logic [31:0]      first_fail_inst,
  output logic [1:0]       dbg_state
);

  // pcEn and OpDone are single-cycle strobes with no backpressure: a strobe is
  // consumed in the cycle it is high, and the scoreboard never stalls either side.

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int               DR_W    = $clog2(CHK_LAT + 1);
  localparam logic [DR_W-1:0]  DR_LAST = DR_W'(CHK_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TO_W-1:0]  WD_MAX  = '1;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            num_q, num_d;
  logic [CNT_W-1:0]            issued_q, issued_d;
  logic [TO_W-1:0]             wd_q, wd_d;
  logic [DR_W-1:0]             drain_q, drain_d;
  logic [CHK_LAT-1:0]          dl_vld_q, dl_vld_d;
  logic [CHK_LAT-1:0][31:0]    dl_inst_q, dl_inst_d;
  logic [CNT_W-1:0]            pass_q, pass_d;
  logic [CNT_W-1:0]            fail_q, fail_d;
  logic [CNT_W-1:0]            spur_q, spur_d;
  logic                        timeout_q, timeout_d;
  logic                        ffv_q, ffv_d;
  logic [31:0]                 ffi_q, ffi_d;

  logic                        scoring;
  logic                        tail_vld;
  logic [31:0]                 tail_inst;
  logic [TO_W:0]               wd_inc;
  logic                        wd_fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    issued_d  = issued_q;
    wd_d      = wd_q;
    drain_d   = drain_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    spur_d    = spur_q;
    timeout_d = timeout_q;
    ffv_d     = ffv_q;
    ffi_d     = ffi_q;

    // Only issues that still count toward this run's quota enter the line as valid.
    dl_vld_d[0]  = (state_q == S_RUN) && pcEn && (issued_q != num_q);
    dl_inst_d[0] = inst;
    for (int i = 1; i < CHK_LAT; i++) begin
      dl_vld_d[i]  = dl_vld_q[i-1];
      dl_inst_d[i] = dl_inst_q[i-1];
    end

    tail_vld  = dl_vld_q[CHK_LAT-1];
    tail_inst = dl_inst_q[CHK_LAT-1];
    scoring   = (state_q == S_RUN) || (state_q == S_DRAIN);
    wd_inc    = {1'b0, wd_q} + (TO_W+1)'(1);
    wd_fire   = (timeout_lim != '0) && (wd_inc == {1'b0, timeout_lim});

    if (scoring) begin
      if (tail_vld && OpDone) begin
        pass_d = sat_inc(pass_q);
      end else if (tail_vld) begin
        fail_d = sat_inc(fail_q);
        if (!ffv_q) begin
          ffv_d = 1'b1;
          ffi_d = tail_inst;
        end
      end else if (OpDone) begin
        spur_d = sat_inc(spur_q);
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          num_d     = num_insts;
          issued_d  = '0;
          wd_d      = '0;
          pass_d    = '0;
          fail_d    = '0;
          spur_d    = '0;
          timeout_d = 1'b0;
          ffv_d     = 1'b0;
          ffi_d     = '0;
          dl_vld_d  = '0;
        end
      end
      S_RUN: begin
        if (issued_q == num_q) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else if (pcEn) begin
          issued_d = issued_q + CNT_W'(1);
          wd_d     = '0;
        end else begin
          if (wd_q != WD_MAX) wd_d = wd_q + TO_W'(1);
          if (wd_fire) begin
            timeout_d = 1'b1;
            state_d   = S_DRAIN;
            drain_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        // CHK_LAT cycles here lets the youngest tracked entry reach the tail.
        if (drain_q == DR_LAST) state_d = S_DONE;
        else                    drain_d = drain_q + DR_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      issued_q  <= '0;
      wd_q      <= '0;
      drain_q   <= '0;
      dl_vld_q  <= '0;
      dl_inst_q <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      spur_q    <= '0;
      timeout_q <= 1'b0;
      ffv_q     <= 1'b0;
      ffi_q     <= '0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      issued_q  <= issued_d;
      wd_q      <= wd_d;
      drain_q   <= drain_d;
      dl_vld_q  <= dl_vld_d;
      dl_inst_q <= dl_inst_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      spur_q    <= spur_d;
      timeout_q <= timeout_d;
      ffv_q     <= ffv_d;
      ffi_q     <= ffi_d;
    end
  end

  assign busy            = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done            = (state_q == S_DONE);
  assign test_pass       = done && (fail_q == '0) && (spur_q == '0) && !timeout_q;
  assign timeout         = timeout_q;
  assign pass_cnt        = pass_q;
  assign fail_cnt        = fail_q;
  assign spur_cnt        = spur_q;
  assign first_fail_vld  = ffv_q;
  assign first_fail_inst = ffi_q;
  assign dbg_state       = state_q;

endmodule
